pipe_reg_chain: RTL

- Parametrised, bubble-collapsing pipeline register chain: DEPTH stages of WIDTH-bit data, each stage with its own valid bit.
- Valid/ready handshake on both ends, a global enable (stall) and a synchronous flush.
- Used between out-of-order core stages (issue -> execute, execute -> writeback) in place of plain enable-DFF walls, so bubbles are squeezed out and mispredict flushes clear in-flight entries.

---
 rtl/pipe_reg_chain_if.sv | 12 +
 rtl/pipe_reg_chain.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if: one valid/ready/data stream endpoint.
// The master drives valid/data, the slave drives ready.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: bubble-collapsing valid/ready register chain with global stall and flush.
// Defining PIPE_REG_CHAIN_OCCUPANCY_EN adds a registered occupancy output and its bound check.

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
module pipe_reg_chain_occ_chk #(
    parameter int DEPTH = 2,
    parameter int OCC_W = 2
) (
    input logic             clk,
    input logic             reset,
    input logic [OCC_W-1:0] occupancy
);
    occ_bound_a: assert property (@(posedge clk) disable iff (reset) occupancy <= OCC_W'(DEPTH));
endmodule
`endif

module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    pipe_reg_chain_if.slave  in_if,
    pipe_reg_chain_if.master out_if
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    // A stage may move when any stage at or beyond it is empty (a bubble to squeeze out).
    function automatic logic hole_at_or_after(input logic [DEPTH-1:0] vec, input int lo);
        logic h;
        h = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (j >= lo) begin
                h = h | ~vec[j];
            end else begin
                h = h;
            end
        end
        return h;
    endfunction

    logic                 go_s;
    logic [DEPTH-1:0]     v_all_s;
    logic [WIDTH-1:0]     d_all_s [DEPTH];

    assign go_s = enable & ~flush;

    assign out_if.valid = v_all_s[DEPTH-1];
    assign out_if.data  = d_all_s[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_nxt_all_s;
    logic [OCC_W-1:0] occ_r;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + OCC_W'(vec[k]);
        end
        return cnt;
    endfunction

    // Occupancy register tracks the valid-bit count the stages take at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_r <= '0;
        end else begin
            occ_r <= popcount(v_nxt_all_s);
        end
    end

    assign occupancy = occ_r;

    pipe_reg_chain_occ_chk #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_occ_chk (
        .clk       (clk),
        .reset     (reset),
        .occupancy (occ_r)
    );
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_r;
        logic             v_nxt_s;
        logic             up_v_s;
        logic             adv_s;
        logic [WIDTH-1:0] d_r;
        logic [WIDTH-1:0] d_nxt_s;
        logic [WIDTH-1:0] up_d_s;

        // Closed form of the output-to-input ready chain; depends on state and out_ready only.
        assign adv_s = go_s & (out_if.ready | hole_at_or_after(v_all_s, i));

        if (i == 0) begin : g_head
            assign up_v_s      = in_if.valid;
            assign up_d_s      = in_if.data;
            assign in_if.ready = adv_s;
        end else begin : g_body
            assign up_v_s = v_all_s[i-1];
            assign up_d_s = d_all_s[i-1];
        end

        assign v_all_s[i] = v_r;
        assign d_all_s[i] = d_r;

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        assign v_nxt_all_s[i] = v_nxt_s;
`endif

        // Flush only drops valid; an advancing stage takes its upstream neighbour.
        always_comb begin
            v_nxt_s = v_r;
            d_nxt_s = d_r;
            if (flush) begin
                v_nxt_s = 1'b0;
            end else if (adv_s) begin
                v_nxt_s = up_v_s;
                d_nxt_s = up_d_s;
            end else begin
                v_nxt_s = v_r;
                d_nxt_s = d_r;
            end
        end

        // Stage register with synchronous reset clearing both valid and data.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
                d_r <= '0;
            end else begin
                v_r <= v_nxt_s;
                d_r <= d_nxt_s;
            end
        end
    end

endmodule
